// File: rtl/crc_pkg.sv
// Shared types, default constants and the single-bit CRC step for the serial CRC checker.
// Contents: state_t {SKIP,CALC,REPORT}, CRC-4-ITU defaults, crc_step().
// The step function works on a CRC_MAX_W-bit container so one definition serves any width up to 32.
package crc_pkg;

  typedef enum logic [1:0] {
    SKIP   = 2'd0,
    CALC   = 2'd1,
    REPORT = 2'd2
  } state_t;

  // CRC-4-ITU: x^4 + x + 1, zero preset
  localparam int          CRC_W_DEF    = 4;
  localparam logic [3:0]  POLY_DEF     = 4'h3;
  localparam logic [3:0]  CRC_INIT_DEF = 4'h0;
  localparam int          CRC_MAX_W    = 32;

  // One MSB-first LFSR step of a w-bit CRC held in the low bits of a CRC_MAX_W container.
  function automatic logic [CRC_MAX_W-1:0] crc_step(
    input logic [CRC_MAX_W-1:0] lfsr,
    input logic                 din,
    input logic [CRC_MAX_W-1:0] poly,
    input int unsigned          w = CRC_W_DEF
  );
    logic [CRC_MAX_W-1:0] top;
    logic [CRC_MAX_W-1:0] mask;
    logic                 fb;
    top  = lfsr >> (w - 1);
    fb   = din ^ top[0];
    mask = {CRC_MAX_W{1'b1}} >> (CRC_MAX_W - w);
    return ((lfsr << 1) ^ (fb ? poly : '0)) & mask;
  endfunction

endpackage

// File: rtl/crc_lfsr_serial.sv
// Bit-serial MSB-first CRC register: one step per shift, synchronous clear to CRC_INIT.
// Ports: clk/rstb (async active-low), clr (wins over shift), shift, din; crc = current register.
// Latency: crc reflects a shifted bit one clock after shift is sampled.
module crc_lfsr_serial
  import crc_pkg::*;
#(
  parameter int               CRC_W    = CRC_W_DEF,
  parameter logic [CRC_W-1:0] POLY     = POLY_DEF,
  parameter logic [CRC_W-1:0] CRC_INIT = CRC_INIT_DEF
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             clr,
  input  logic             shift,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0]     r_crc;
  logic [CRC_MAX_W-1:0] w_nxt;

  assign w_nxt = crc_step(CRC_MAX_W'(r_crc), din, CRC_MAX_W'(POLY), CRC_W);
  assign crc   = r_crc;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_crc <= CRC_INIT;
    end else if (clr) begin
      r_crc <= CRC_INIT;
    end else if (shift) begin
      r_crc <= CRC_W'(w_nxt);
    end
  end

endmodule

// File: rtl/serial_crc_checker_param.sv
// Serial CRC checker: drops SKIP_BITS header bits, CRCs DATA_BITS of every DATA_BITS+GAP_BITS slot,
// compares with crc_rx on frame_end and pulses result_valid/cts/cts_error one cycle later.
// Ports: sys_clk, sys_resetb (async active-low), bit_valid/bit_in, frame_end/cmd/crc_rx, err_clr;
//        crc_out, result_valid, cts, cts_error, report_busy, err_cnt (saturating mismatch count).
// SKIP_BITS and REPORT_BITS are expected to be >= 1.
module serial_crc_checker_param
  import crc_pkg::*;
#(
  parameter int               CRC_W       = CRC_W_DEF,
  parameter logic [CRC_W-1:0] POLY        = POLY_DEF,
  parameter logic [CRC_W-1:0] CRC_INIT    = CRC_INIT_DEF,
  parameter int               SKIP_BITS   = 4,
  parameter int               DATA_BITS   = 8,
  parameter int               GAP_BITS    = 1,
  parameter int               CMD_W       = 4,
  parameter logic [CMD_W-1:0] REPORT_CMD  = 4'hE,
  parameter int               REPORT_BITS = 17,
  parameter int               ERR_W       = 8
) (
  input  logic             sys_clk,
  input  logic             sys_resetb,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             frame_end,
  input  logic [CMD_W-1:0] cmd,
  input  logic [CRC_W-1:0] crc_rx,
  input  logic             err_clr,
  output logic [CRC_W-1:0] crc_out,
  output logic             result_valid,
  output logic             cts,
  output logic             cts_error,
  output logic             report_busy,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int SLOT    = DATA_BITS + GAP_BITS;
  localparam int MAX_SR  = (SKIP_BITS > REPORT_BITS) ? SKIP_BITS : REPORT_BITS;
  localparam int CNT_MAX = (MAX_SR > SLOT) ? MAX_SR : SLOT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SKIP_LAST   = CNT_W'(SKIP_BITS - 1);
  localparam logic [CNT_W-1:0] REPORT_LAST = CNT_W'(REPORT_BITS - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST   = CNT_W'(SLOT - 1);
  localparam logic [CNT_W-1:0] DATA_END    = CNT_W'(DATA_BITS);

  // One counter serves all states: header bits in SKIP, slot position in CALC,
  // ignored bits in REPORT. Every state change resets it.
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_clr, w_shift;
  logic [CRC_W-1:0] w_crc;
  logic             r_res_vld, r_cts, r_cts_err;
  logic [ERR_W-1:0] r_err_cnt;

  crc_lfsr_serial #(
    .CRC_W    (CRC_W),
    .POLY     (POLY),
    .CRC_INIT (CRC_INIT)
  ) u_lfsr (
    .clk   (sys_clk),
    .rstb  (sys_resetb),
    .clr   (w_clr),
    .shift (w_shift),
    .din   (bit_in),
    .crc   (w_crc)
  );

  always_ff @(posedge sys_clk or negedge sys_resetb) begin
    if (!sys_resetb) begin
      r_state <= SKIP;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr       = 1'b0;
    w_shift     = 1'b0;
    if (frame_end) begin
      // frame_end overrides any state; a coincident bit is dropped
      w_clr       = 1'b1;
      w_cnt_nxt   = '0;
      w_state_nxt = (cmd == REPORT_CMD) ? REPORT : SKIP;
    end else if (bit_valid) begin
      unique case (r_state)
        SKIP: begin
          if (r_cnt == SKIP_LAST) begin
            w_state_nxt = CALC;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        CALC: begin
          w_shift   = (r_cnt < DATA_END);
          w_cnt_nxt = (r_cnt == SLOT_LAST) ? '0 : r_cnt + CNT_W'(1);
        end
        REPORT: begin
          if (r_cnt == REPORT_LAST) begin
            w_state_nxt = SKIP;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = SKIP;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Compare uses the LFSR before this cycle's clear; pulses live for one cycle only.
  always_ff @(posedge sys_clk or negedge sys_resetb) begin
    if (!sys_resetb) begin
      r_res_vld <= 1'b0;
      r_cts     <= 1'b0;
      r_cts_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_res_vld <= frame_end;
      r_cts     <= frame_end && (w_crc == crc_rx);
      r_cts_err <= frame_end && (w_crc != crc_rx);
      if (err_clr) begin
        r_err_cnt <= '0;
      end else if (r_cts_err && (r_err_cnt != {ERR_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
    end
  end

  assign crc_out      = w_crc;
  assign result_valid = r_res_vld;
  assign cts          = r_cts;
  assign cts_error    = r_cts_err;
  assign report_busy  = (r_state == REPORT);
  assign err_cnt      = r_err_cnt;

endmodule

// File: tb/tb_serial_crc_checker_param.sv
// Self-checking bench for serial_crc_checker_param: constant vector table, hand-written
// corner sequences and a randomized run against a frame-level reference model.
// Two instances share stimulus; the second uses ERR_W=2 for the saturation case.
module tb_serial_crc_checker_param;

  logic       sys_clk = 1'b0;
  logic       sys_resetb = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       frame_end = 1'b0;
  logic [3:0] cmd = 4'h0;
  logic [3:0] crc_rx = 4'h0;
  logic       err_clr = 1'b0;

  logic [3:0] crc_out, crc_out_b;
  logic       result_valid, cts, cts_error, report_busy;
  logic       result_valid_b, cts_b, cts_error_b, report_busy_b;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt_b;

  always #5 sys_clk = ~sys_clk;

  serial_crc_checker_param u_dut (
    .sys_clk(sys_clk), .sys_resetb(sys_resetb), .bit_valid(bit_valid), .bit_in(bit_in),
    .frame_end(frame_end), .cmd(cmd), .crc_rx(crc_rx), .err_clr(err_clr),
    .crc_out(crc_out), .result_valid(result_valid), .cts(cts), .cts_error(cts_error),
    .report_busy(report_busy), .err_cnt(err_cnt)
  );

  serial_crc_checker_param #(.ERR_W(2)) u_dut_b (
    .sys_clk(sys_clk), .sys_resetb(sys_resetb), .bit_valid(bit_valid), .bit_in(bit_in),
    .frame_end(frame_end), .cmd(cmd), .crc_rx(crc_rx), .err_clr(err_clr),
    .crc_out(crc_out_b), .result_valid(result_valid_b), .cts(cts_b), .cts_error(cts_error_b),
    .report_busy(report_busy_b), .err_cnt(err_cnt_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  bit m_q[$];          // data bits of the current frame, in arrival order
  int m_p    = 0;      // non-report bits seen since frame start
  int m_rpt  = 0;      // report bits still to be ignored
  bit m_rv   = 0;
  bit m_cts  = 0;
  bit m_cerr = 0;
  int m_err  = 0;
  int m_err2 = 0;

  // Remainder of M(x)*x^4 mod (x^4+x+1) by polynomial long division.
  function automatic logic [3:0] ref_crc();
    logic [4:0] rem;
    bit b;
    rem = '0;
    for (int i = 0; i < m_q.size() + 4; i++) begin
      b = (i < m_q.size()) ? m_q[i] : 1'b0;
      rem = {rem[3:0], b};
      if (rem[4]) rem = rem ^ 5'h13;
    end
    return rem[3:0];
  endfunction

  task automatic model_update();
    logic [3:0] c;
    if (!sys_resetb) begin
      m_q.delete(); m_p = 0; m_rpt = 0;
      m_rv = 0; m_cts = 0; m_cerr = 0; m_err = 0; m_err2 = 0;
      return;
    end
    if (err_clr) begin
      m_err = 0; m_err2 = 0;
    end else if (m_cerr) begin
      if (m_err < 255) m_err++;
      if (m_err2 < 3) m_err2++;
    end
    if (frame_end) begin
      c = ref_crc();
      m_rv = 1; m_cts = (c == crc_rx); m_cerr = !m_cts;
      m_q.delete(); m_p = 0;
      m_rpt = (cmd == 4'hE) ? 17 : 0;
    end else begin
      m_rv = 0; m_cts = 0; m_cerr = 0;
      if (bit_valid) begin
        if (m_rpt > 0) m_rpt--;
        else begin
          if (m_p >= 4 && ((m_p - 4) % 9) < 8) m_q.push_back(bit_in);
          m_p++;
        end
      end
    end
  endtask

  task automatic model_check();
    chk("m_crc_out", crc_out, ref_crc());
    chk("m_result_valid", result_valid, m_rv);
    chk("m_cts", cts, m_cts);
    chk("m_cts_error", cts_error, m_cerr);
    chk("m_report_busy", report_busy, m_rpt > 0);
    chk("m_err_cnt", err_cnt, m_err);
    chk("m_err_cnt_b", err_cnt_b, m_err2);
  endtask

  // Called at a negedge with inputs set; returns at the next negedge with pulses cleared.
  task automatic step();
    @(posedge sys_clk);
    model_update();
    @(negedge sys_clk);
    model_check();
    bit_valid = 1'b0; frame_end = 1'b0; err_clr = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1; bit_in = b;
    step();
  endtask

  task automatic send_fe(input logic [3:0] c, input logic [3:0] r);
    frame_end = 1'b1; cmd = c; crc_rx = r;
    step();
  endtask

  task automatic send_data(input int nbits, input logic [7:0] d);
    logic [7:0] v;
    v = d;
    for (int k = 0; k < 4; k++) send_bit(1'b0);
    for (int j = 0; j < nbits; j++) send_bit(v[7 - j]);
    if (nbits == 8) send_bit(1'b0);
  endtask

  typedef struct {
    int         nbits;
    logic [7:0] data;
    logic [3:0] rx;
    logic [3:0] exp_crc;
    logic       exp_cts;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{8, 8'hFF, 4'h4, 4'h4, 1'b1};
    vt[1] = '{8, 8'hFF, 4'h5, 4'h4, 1'b0};
    vt[2] = '{7, 8'hFE, 4'hA, 4'hA, 1'b1};
    vt[3] = '{0, 8'h00, 4'h0, 4'h0, 1'b1};
    vt[4] = '{8, 8'h80, 4'hE, 4'hE, 1'b1};
    vt[5] = '{8, 8'h01, 4'h3, 4'h3, 1'b1};
    vt[6] = '{1, 8'h80, 4'h2, 4'h3, 1'b0};

    // reset state
    @(negedge sys_clk);
    step(); step();
    chk("rst_crc_out", crc_out, 4'h0);
    chk("rst_result_valid", result_valid, 1'b0);
    chk("rst_cts", {cts, cts_error}, 2'b00);
    chk("rst_report_busy", report_busy, 1'b0);
    chk("rst_err_cnt", err_cnt, 8'h0);
    sys_resetb = 1'b1;
    step();

    // table of complete frames
    for (int i = 0; i < 7; i++) begin
      send_data(vt[i].nbits, vt[i].data);
      chk($sformatf("tbl%0d_crc", i), crc_out, vt[i].exp_crc);
      send_fe(4'h0, vt[i].rx);
      chk($sformatf("tbl%0d_rv", i), result_valid, 1'b1);
      chk($sformatf("tbl%0d_cts", i), cts, vt[i].exp_cts);
      chk($sformatf("tbl%0d_cts_error", i), cts_error, !vt[i].exp_cts);
      step();
      chk($sformatf("tbl%0d_rv_off", i), result_valid, 1'b0);
      chk($sformatf("tbl%0d_crc_clr", i), crc_out, 4'h0);
    end

    // report window ignores 17 bits of 1, then a normal frame matches
    send_fe(4'hE, 4'h0);
    chk("rpt_busy_on", report_busy, 1'b1);
    chk("rpt_fe_cts", cts, 1'b1);
    for (int k = 0; k < 16; k++) send_bit(1'b1);
    chk("rpt_busy_16", report_busy, 1'b1);
    chk("rpt_crc_frozen", crc_out, 4'h0);
    send_bit(1'b1);
    chk("rpt_busy_off", report_busy, 1'b0);
    send_data(8, 8'hFF);
    chk("rpt_after_crc", crc_out, 4'h4);
    send_fe(4'h0, 4'h4);
    chk("rpt_after_cts", cts, 1'b1);

    // bit coinciding with frame_end is dropped
    send_data(7, 8'hFE);
    bit_valid = 1'b1; bit_in = 1'b1;
    send_fe(4'h0, 4'hA);
    chk("coll_cts", cts, 1'b1);
    chk("coll_cts_error", cts_error, 1'b0);

    // saturation and clear priority, back-to-back frame_end
    err_clr = 1'b1; step(); step();
    chk("clr_err_cnt", err_cnt, 8'h0);
    for (int k = 0; k < 5; k++) begin
      send_fe(4'h0, 4'h5);
      chk("b2b_cts_error", cts_error, 1'b1);
    end
    step(); step();
    chk("sat_err_cnt_b", err_cnt_b, 2'd3);
    chk("sat_err_cnt", err_cnt, 8'd5);
    send_fe(4'h0, 4'h5);
    err_clr = 1'b1;
    step();
    chk("clr_wins_b", err_cnt_b, 2'd0);
    chk("clr_wins", err_cnt, 8'd0);
    for (int k = 0; k < 260; k++) send_fe(4'h0, 4'h9);
    step(); step();
    chk("sat_err_cnt_255", err_cnt, 8'hFF);

    // reset mid-frame with a result pulse pending
    for (int k = 0; k < 4; k++) send_bit(1'b0);
    for (int k = 0; k < 5; k++) send_bit(1'b1);
    chk("mid_crc", crc_out, 4'h7);
    send_fe(4'h0, 4'h1);
    chk("mid_pulse", cts_error, 1'b1);
    sys_resetb = 1'b0;
    #1;
    chk("arst_rv", result_valid, 1'b0);
    chk("arst_cts_error", cts_error, 1'b0);
    chk("arst_err_cnt", err_cnt, 8'h0);
    chk("arst_crc_out", crc_out, 4'h0);
    step();
    sys_resetb = 1'b1;
    step();
    send_data(8, 8'hFF);
    send_fe(4'h0, 4'h4);
    chk("post_rst_cts", cts, 1'b1);

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      bit_valid = ($urandom_range(0, 3) != 0);
      bit_in    = $urandom_range(0, 1);
      err_clr   = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 39) == 0) begin
        frame_end = 1'b1;
        cmd       = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
        crc_rx    = ($urandom_range(0, 1) == 1) ? ref_crc() : 4'($urandom_range(0, 15));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
